mdu_issue: RTL
==============

Name: mdu_issue

Overview:
- Issue and hazard front-end sitting directly upstream of the E-stage multiply/divide unit (`mdu`).
- Accepts decoded HI/LO-class operations from the EX pipeline via a valid/ready handshake and drives the mdu's `start`/`mod`/`d1`/`d2` as registered one-shot commands.
- Tracks per-operation latency with its own countdown, so the pipeline stall covers the cycle before mdu `busy` rises and also covers `madd`, which never raises `busy`.
- Serves `mfhi`/`mflo` reads from the mdu's `HI`/`LO` outputs only when no write is outstanding.

Parameters:
- MUL_LAT, 5, stall cycles after mult/multu issue (>=1)
- DIV_LAT, 10, stall cycles after div/divu issue (>=1)
- MADD_LAT, 5, stall cycles after madd issue (>=1)
- CNT_W, 4, countdown width; every LAT must be < 2^CNT_W

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  operation request present
- req_op  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 mfhi, 8 mflo, others illegal
- req_a  in  32  rs operand
- req_b  in  32  rt operand
- req_ready  out  1  request accepted at this edge when high with req_valid
- flush  in  1  drop any unaccepted request; no effect on in-flight work
- mdu_start  out  1  registered start pulse to mdu
- mdu_mod  out  3  0 mul_s, 1 mul_u, 2 div_s, 3 div_u, 4 moveto_HI, 5 moveto_LO, 6 madd, 7 NOP
- mdu_d1  out  32  operand 1 to mdu
- mdu_d2  out  32  operand 2 to mdu
- mdu_busy  in  1  mdu busy
- hi_in  in  32  mdu HI
- lo_in  in  32  mdu LO
- rd_valid  out  1  read result valid pulse
- rd_data  out  32  mfhi/mflo result
- stall  out  1  to hazard unit: HI/LO resource occupied
- illegal_op  out  1  one-cycle pulse for an accepted undefined req_op

Behaviour:
- Reset (rst=0, async): cnt=0, mdu_start=0, mdu_mod=7 (NOP), mdu_d1=mdu_d2=0, rd_valid=0, rd_data=0, illegal_op=0. Reset mid-operation abandons tracking immediately.
- mdu_mod idles at 7 on every cycle without a command. Required because the mdu writes HI/LO whenever mod is 4 or 5, even without start.
- req_ready = (cnt==0) && !mdu_busy && !flush. Combinational; does not depend on req_valid.
- An accept at edge N loads the command registers. They are valid only during cycle N+1; the registers return to start=0, mod=7 at edge N+1.
  - mult/multu: start=1, mod=0/1, d1=req_a, d2=req_b; cnt<=MUL_LAT.
  - div/divu: start=1, mod=2/3; cnt<=DIV_LAT. A zero divisor is issued unchanged; HI/LO are architecturally undefined.
  - madd: start=1, mod=6; cnt<=MADD_LAT.
  - mthi/mtlo: start=0, mod=4/5, d1=req_a; cnt<=1.
  - mfhi/mflo: no mdu command; rd_data<=hi_in/lo_in sampled at edge N; rd_valid=1 during cycle N+1 only.
  - illegal: no command; illegal_op=1 during cycle N+1 only.
- cnt decrements by 1 each edge when nonzero and no accept occurs. An accept cannot occur while cnt!=0.
- stall = (cnt!=0) || mdu_busy. Asserted from cycle N+1 after any write-class accept, with no gap before mdu_busy rises.
- Because cnt>=1 after every write, a read is never accepted before the mdu's HI/LO update edge.
- flush=1: req_ready=0; nothing accepted that edge. cnt, pending rd_valid and the command pulse proceed unaffected.
- Back-to-back reads: one accept per cycle, rd_valid is continuous.

Test Plan:
- Reset: hold rst=0 with req_valid=1 -> mdu_mod=7, start=0, stall=0, rd_valid=0. Release -> req_ready=1.
- mult a=-3, b=7 accepted at edge N:
  - cycle N+1: start=1, mod=0, d1=0xFFFFFFFD, d2=7, stall=1.
  - stall high through 5 cycles, then mdu busy drop.
  - mflo then accepted -> rd_data=0xFFFFFFEB; mfhi -> 0xFFFFFFFF.
- divu 100/7:
  - req_ready=0 for 10+ cycles.
  - mfhi -> rd_data=2; mflo -> 14.
- madd after mult 2*3 with a=4, b=5:
  - stall=1 for MADD_LAT cycles with mdu_busy=0.
  - mflo -> 26.
- mthi 0x12345678 then mfhi requested back-to-back:
  - first accepted; req_ready=0 one cycle.
  - mfhi accepted next edge -> rd_data=0x12345678.
  - mdu_mod=7 in every idle cycle.
- flush with req_valid=1, req_op=0 -> no accept, start stays 0.
- req_op=12 -> illegal_op pulse, no mdu command, stall=0.

Source files
------------

// File: rtl/mdu_issue.sv
// Issue/hazard front-end for the E-stage mdu: registered one-shot commands,
// latency countdown for stall, and HI/LO read service.
module mdu_issue #(
  parameter int MUL_LAT  = 5,
  parameter int DIV_LAT  = 10,
  parameter int MADD_LAT = 5,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        mdu_start,
  output logic [2:0]  mdu_mod,
  output logic [31:0] mdu_d1,
  output logic [31:0] mdu_d2,
  input  logic        mdu_busy,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        illegal_op
);

  localparam logic [2:0] MOD_NOP = 3'd7;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [2:0]       mod_q, mod_d;
  logic [31:0]      d1_q, d1_d;
  logic [31:0]      d2_q, d2_d;
  logic             rdv_q, rdv_d;
  logic [31:0]      rdd_q, rdd_d;
  logic             ill_q, ill_d;
  logic             accept;

  logic is_mul, is_div, is_madd;
  logic is_mt, is_mf;

  assign req_ready = (cnt_q == '0) && !mdu_busy && !flush;
  assign accept    = req_valid && req_ready;

  assign is_mul  = (req_op == 4'd0) || (req_op == 4'd1);
  assign is_div  = (req_op == 4'd2) || (req_op == 4'd3);
  assign is_mt   = (req_op == 4'd4) || (req_op == 4'd5);
  assign is_madd = (req_op == 4'd6);
  assign is_mf   = (req_op == 4'd7) || (req_op == 4'd8);

  always_comb begin
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    start_d = 1'b0;
    mod_d   = MOD_NOP;
    d1_d    = d1_q;
    d2_d    = d2_q;
    rdv_d   = 1'b0;
    rdd_d   = rdd_q;
    ill_d   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_mul: begin
          start_d = 1'b1;
          mod_d   = {2'b00, req_op[0]};
          d1_d    = req_a;
          d2_d    = req_b;
          cnt_d   = CNT_W'(MUL_LAT);
        end
        is_div: begin
          start_d = 1'b1;
          mod_d   = {2'b01, req_op[0]};
          d1_d    = req_a;
          d2_d    = req_b;
          cnt_d   = CNT_W'(DIV_LAT);
        end
        is_mt: begin
          mod_d = {2'b10, req_op[0]};
          d1_d  = req_a;
          cnt_d = CNT_W'(1);
        end
        is_madd: begin
          start_d = 1'b1;
          mod_d   = 3'd6;
          d1_d    = req_a;
          d2_d    = req_b;
          cnt_d   = CNT_W'(MADD_LAT);
        end
        is_mf: begin
          rdv_d = 1'b1;
          rdd_d = req_op[0] ? hi_in : lo_in;
        end
        default: ill_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
      mod_q   <= MOD_NOP;
      d1_q    <= '0;
      d2_q    <= '0;
      rdv_q   <= 1'b0;
      rdd_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
      mod_q   <= mod_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
      ill_q   <= ill_d;
    end
  end

  assign mdu_start  = start_q;
  assign mdu_mod    = mod_q;
  assign mdu_d1     = d1_q;
  assign mdu_d2     = d2_q;
  assign rd_valid   = rdv_q;
  assign rd_data    = rdd_q;
  assign illegal_op = ill_q;
  assign stall      = (cnt_q != '0) || mdu_busy;

endmodule
